// File: rtl/simt_lsu_serializer_if.sv
// Request, completion and sram word-bus signals of the SIMT load/store serializer.
// master = the serializer itself, slave = the execute stage / sram side.
interface simt_lsu_serializer_if #(
  parameter int LANES = 8
);
  logic                 start;
  logic                 is_store;
  logic [LANES-1:0]     lane_mask;
  logic [LANES*32-1:0]  lane_addr;
  logic [LANES*32-1:0]  lane_wd;
  logic [13:0]          mem_addr;
  logic                 mem_we;
  logic [31:0]          mem_wd;
  logic [31:0]          mem_rd;
  logic                 busy;
  logic                 done;
  logic [LANES*32-1:0]  lane_rd;
  logic [LANES-1:0]     lane_err;

  modport master (
    input  start, is_store, lane_mask, lane_addr, lane_wd, mem_rd,
    output mem_addr, mem_we, mem_wd, busy, done, lane_rd, lane_err
  );

  modport slave (
    output start, is_store, lane_mask, lane_addr, lane_wd, mem_rd,
    input  mem_addr, mem_we, mem_wd, busy, done, lane_rd, lane_err
  );
endinterface

// File: rtl/simt_lsu_serializer.sv
// Serializes one SIMT load/store onto a single-port sram word bus, one active
// aligned lane per cycle (lowest lane first), gathering load data per lane.
module simt_lsu_serializer #(
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  simt_lsu_serializer_if.master bus
);
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                is_store_q, is_store_d;
  logic [LANES-1:0]    pending_q, pending_d;
  logic [LANES-1:0]    lane_err_q, lane_err_d;
  logic [LANES*32-1:0] addr_q, addr_d;
  logic [LANES*32-1:0] wd_q, wd_d;
  logic [LANES*32-1:0] lane_rd_q, lane_rd_d;
  logic [LANES-1:0]    aligned_s;
  logic [IDXW-1:0]     cur_s;
  logic [IDXW+4:0]     cur_base_s;

  // Alignment of the incoming request and the lowest still-pending lane.
  always_comb begin
    aligned_s = '0;
    cur_s     = '0;
    for (int i = 0; i < LANES; i++) begin
      aligned_s[i] = (bus.lane_addr[32*i +: 2] == 2'b00);
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      cur_s = pending_q[i] ? IDXW'(i) : cur_s;
    end
    cur_base_s = {cur_s, 5'd0};
  end

  // Next-state logic: capture at start, retire one lane per RUN cycle.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    pending_d  = pending_q;
    lane_err_d = lane_err_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    lane_rd_d  = lane_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          is_store_d = bus.is_store;
          addr_d     = bus.lane_addr;
          wd_d       = bus.lane_wd;
          pending_d  = bus.lane_mask & aligned_s;
          lane_err_d = bus.lane_mask & ~aligned_s;
          lane_rd_d  = '0;
          state_d    = (|(bus.lane_mask & aligned_s)) ? ST_RUN : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        pending_d[cur_s] = 1'b0;
        if (!is_store_q) begin
          lane_rd_d[cur_base_s +: 32] = bus.mem_rd;
        end else begin
          lane_rd_d = lane_rd_q;
        end
        state_d = (pending_d == '0) ? ST_DONE : ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The sram bus is decoded from the state register so reset silences it at once.
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wd   = '0;
    if (state_q == ST_RUN) begin
      bus.mem_we   = is_store_q;
      bus.mem_addr = addr_q[cur_base_s + (IDXW+5)'(2) +: 14];
      bus.mem_wd   = wd_q[cur_base_s +: 32];
    end else begin
      bus.mem_we   = 1'b0;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.lane_rd  = lane_rd_q;
  assign bus.lane_err = lane_err_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      pending_q  <= '0;
      lane_err_q <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
      lane_rd_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      pending_q  <= pending_d;
      lane_err_q <= lane_err_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      lane_rd_q  <= lane_rd_d;
    end
  end
endmodule

// File: tb/tb_simt_lsu_serializer.sv
// Directed and randomized checks of simt_lsu_serializer against a lane-list
// reference model and a bench-owned sram.
module tb_simt_lsu_serializer;
  localparam int LANES = 8;

  logic clk;
  logic reset;
  simt_lsu_serializer_if #(.LANES(LANES)) bus ();
  simt_lsu_serializer #(.LANES(LANES)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] sram    [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic        pl_we;
  logic [13:0] pl_addr;
  logic [31:0] pl_data;
  logic [31:0] a_addr [LANES];
  logic [31:0] a_wd   [LANES];
  int n_pass;
  int n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wd;
    else if (pl_we) sram[pl_addr] <= pl_data;
  end
  assign bus.mem_rd = sram[bus.mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = 14'(w); pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
    ref_mem[w] = d;
  endtask

  task automatic scramble();
    bus.start     = 1'b1;
    bus.is_store  = 1'($urandom);
    bus.lane_mask = 8'($urandom);
    for (int i = 0; i < LANES; i++) begin
      bus.lane_addr[32*i +: 32] = $urandom;
      bus.lane_wd[32*i +: 32]   = $urandom;
    end
  endtask

  // Reference: the lane list is the active aligned lanes in ascending order.
  task automatic run_op(input string tag, input bit st, input logic [7:0] mask, input bit noise);
    logic [13:0]  ea[$];
    logic [31:0]  ew[$];
    logic [255:0] erd;
    logic [7:0]   eerr;
    int k;
    erd = '0; eerr = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        if (a_addr[i][1:0] != 2'b00) eerr[i] = 1'b1;
        else begin
          ea.push_back(a_addr[i][15:2]);
          ew.push_back(a_wd[i]);
          if (!st) erd[32*i +: 32] = ref_mem[a_addr[i][15:2]];
        end
      end
    end
    if (st) foreach (ea[j]) ref_mem[ea[j]] = ew[j];
    k = ea.size();
    check({tag, "_idle_busy"}, 256'(bus.busy), 256'd0);
    bus.start = 1'b1; bus.is_store = st; bus.lane_mask = mask;
    for (int i = 0; i < LANES; i++) begin
      bus.lane_addr[32*i +: 32] = a_addr[i];
      bus.lane_wd[32*i +: 32]   = a_wd[i];
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < k; c++) begin
      check({tag, "_run_busy"}, 256'(bus.busy), 256'd1);
      check({tag, "_run_done"}, 256'(bus.done), 256'd0);
      check({tag, "_mem_addr"}, 256'(bus.mem_addr), 256'(ea[c]));
      check({tag, "_mem_we"},   256'(bus.mem_we), 256'(st));
      check({tag, "_mem_wd"},   256'(bus.mem_wd), 256'(ew[c]));
      if (noise) scramble();
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check({tag, "_done"},      256'(bus.done), 256'd1);
    check({tag, "_done_busy"}, 256'(bus.busy), 256'd1);
    check({tag, "_done_we"},   256'(bus.mem_we), 256'd0);
    check({tag, "_done_addr"}, 256'(bus.mem_addr), 256'd0);
    check({tag, "_done_wd"},   256'(bus.mem_wd), 256'd0);
    if (noise) scramble();
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_post_done"}, 256'(bus.done), 256'd0);
    check({tag, "_post_busy"}, 256'(bus.busy), 256'd0);
    check({tag, "_lane_rd"},   bus.lane_rd, erd);
    check({tag, "_lane_err"},  256'(bus.lane_err), 256'(eerr));
  endtask

  initial begin
    int w;
    logic [1:0] lo;
    n_pass = 0; n_total = 0;
    reset = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.lane_mask = '0;
    bus.lane_addr = '0; bus.lane_wd = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", 256'(bus.busy), 256'd0);
    check("rst_done", 256'(bus.done), 256'd0);
    check("rst_we",   256'(bus.mem_we), 256'd0);
    check("rst_addr", 256'(bus.mem_addr), 256'd0);
    check("rst_wd",   256'(bus.mem_wd), 256'd0);
    check("rst_rd",   bus.lane_rd, 256'd0);
    check("rst_err",  256'(bus.lane_err), 256'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) preload(i, $urandom);
    for (int i = 0; i < LANES; i++) preload(16 + i, 32'hA0 + 32'(i));

    // 1: full-mask load of words 0x10..0x17
    for (int i = 0; i < LANES; i++) begin a_addr[i] = 32'h40 + 32'(4*i); a_wd[i] = $urandom; end
    run_op("t1_load8", 1'b0, 8'hFF, 1'b0);

    // 2: sparse store, lanes 2,5,7
    for (int i = 0; i < LANES; i++) begin a_addr[i] = 32'h80 + 32'(4*i); a_wd[i] = 32'h1000 + 32'(i); end
    run_op("t2_store3", 1'b1, 8'b1010_0100, 1'b0);
    for (int i = 32; i < 40; i++) check("t2_sram", 256'(sram[i]), 256'(ref_mem[i]));

    // 3: one misaligned lane plus one good lane
    a_addr[0] = 32'h42; a_addr[1] = 32'h44;
    run_op("t3_misal", 1'b0, 8'h03, 1'b0);

    // 4: nothing to access
    run_op("t4_mask0", 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < LANES; i++) a_addr[i] = 32'h40 + 32'(4*i) + 32'(1 + i % 3);
    run_op("t4_allmis", 1'b1, 8'hFF, 1'b0);

    // 5: start pulses while busy are ignored; next start in first IDLE cycle accepted
    for (int i = 0; i < LANES; i++) begin a_addr[i] = 32'h0001_0000 + 32'h90 + 32'(4*i); a_wd[i] = $urandom; end
    run_op("t5_store4", 1'b1, 8'h0F, 1'b1);
    run_op("t5_b2b", 1'b0, 8'h0F, 1'b0);

    // 6: reset during the 2nd RUN cycle of an 8-lane store
    for (int i = 0; i < LANES; i++) begin a_addr[i] = 32'hC0 + 32'(4*i); a_wd[i] = 32'hDEAD_0000 + 32'(i); end
    bus.start = 1'b1; bus.is_store = 1'b1; bus.lane_mask = 8'hFF;
    for (int i = 0; i < LANES; i++) begin
      bus.lane_addr[32*i +: 32] = a_addr[i];
      bus.lane_wd[32*i +: 32]   = a_wd[i];
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    ref_mem[48] = a_wd[0];
    @(posedge clk); #1;
    check("t6_we_before", 256'(bus.mem_we), 256'd1);
    check("t6_addr_before", 256'(bus.mem_addr), 256'd49);
    reset = 1'b1;
    #1;
    check("t6_we_drop", 256'(bus.mem_we), 256'd0);
    check("t6_busy",    256'(bus.busy), 256'd0);
    check("t6_done",    256'(bus.done), 256'd0);
    check("t6_addr",    256'(bus.mem_addr), 256'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("t6_idle_busy", 256'(bus.busy), 256'd0);
    check("t6_idle_done", 256'(bus.done), 256'd0);
    check("t6_err",       256'(bus.lane_err), 256'd0);
    for (int i = 48; i < 56; i++) check("t6_sram", 256'(sram[i]), 256'(ref_mem[i]));

    // Randomized operations, including aliasing high bits and same-word collisions
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < LANES; i++) begin
        w  = (n % 2 == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
        lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        a_addr[i] = {16'($urandom), 8'h00, 6'(w), lo};
        a_wd[i]   = $urandom;
      end
      run_op("rnd", 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 64; i++) check("final_sram", 256'(sram[i]), 256'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
